// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command master.
// - AXI_ADDR_W / AXI_DATA_W : default bus widths.
// - cmd_state_e             : controller FSM states, also exported on the debug port.
// - cmd_t                   : one single-beat command {write, addr, wdata, wstrb} at default widths.
package axi_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } cmd_state_e;

    typedef struct packed {
        logic                      write;
        logic [AXI_ADDR_W-1:0]     addr;
        logic [AXI_DATA_W-1:0]     wdata;
        logic [AXI_DATA_W/8-1:0]   wstrb;
    } cmd_t;

endpackage

// File: rtl/axi_watchdog_timer.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// expiry in the cycle where the count sits at TIMEOUT_CYCLES-1.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : force the count to zero (takes priority over enable_i)
//   enable_i      : count this cycle
//   expire_o      : combinational, high while enabled with count == TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES = 0 removes the counter entirely and ties expire_o low.
module axi_watchdog_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_ni, clear_i, enable_i};
            assign expire_o      = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_q, count_d;

            // The count saturates at LAST so it can never wrap back below it.
            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (enable_i && (count_q != LAST)) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire_o = enable_i && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns a single-beat command/response handshake into one
// AXI4-Lite read or write, one transaction outstanding at a time.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cmd_*                          : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                          : response out (valid/ready, rdata, err = watchdog timeout)
//   m_aw*, m_w*, m_b*              : AXI4-Lite write channels
//   m_ar*, m_r*                    : AXI4-Lite read channels
//   dbg_state                      : current FSM state
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; a valid, once raised, holds it and its payload
// until that edge. All valids and readies here come straight from flops.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W         = AXI_ADDR_W,
    parameter int unsigned DATA_W         = AXI_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rvalid,
    output logic                m_rready,
    output cmd_state_e          dbg_state
);

    cmd_state_e          state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    logic busy;
    logic wd_expire;
    logic aw_pending, w_pending;
    logic final_hs;

    assign busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

    // Held cleared while idle, so the count is zero in the first busy cycle.
    axi_watchdog_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (state_q == ST_IDLE),
        .enable_i(busy),
        .expire_o(wd_expire)
    );

    // A channel is still outstanding if its valid is up and this edge is not its handshake.
    assign aw_pending = awvalid_q && !m_awready;
    assign w_pending  = wvalid_q && !m_wready;

    // Only the closing B or R handshake beats an expiring watchdog; an AW/W/AR
    // handshake at expiry cannot finish the transaction in budget.
    assign final_hs = ((state_q == ST_WR_RESP) && m_bvalid) ||
                      ((state_q == ST_RD_DATA) && m_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else if (wd_expire && !final_hs) begin
            // Abandon the hung target: drop every bus request and report an error.
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RSP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (awvalid_q && m_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
                    if (!aw_pending && !w_pending) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= m_rdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master with a 16-cycle watchdog. Each command carries
// slave wait counts; the expected bus timing and response are derived from them
// with plain arithmetic (edges counted from command acceptance).
module tb_axi_lite_cmd_master;
    import axi_lite_pkg::*;

    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    cmd_state_e  dbg_state;

    axi_lite_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];   // {err, rdata} per issued command
    time         prev_acc_t;
    int          gap_exp;
    bit          b2b = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic slave_idle();
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    endtask

    // Called at a negedge while idle. Wait counts are in cycles after acceptance.
    task automatic run_txn(input cmd_t c, input int aw_w, input int w_w, input int b_w,
                           input int ar_w, input int r_w, input int rsp_w,
                           input logic [31:0] rd);
        int  aw_e, w_e, wr_e, ar_e, e, lim, k;
        bit  got;
        time acc_t;
        aw_e = aw_w + 1;
        w_e  = w_w + 1;
        wr_e = (aw_e > w_e) ? aw_e : w_e;
        ar_e = ar_w + 1;
        e    = c.write ? (wr_e + b_w + 1) : (ar_e + r_w + 1);
        lim  = (e > TO) ? TO : e;
        if (e > TO)       exp_q.push_back({1'b1, 32'h0});
        else if (c.write) exp_q.push_back({1'b0, 32'h0});
        else              exp_q.push_back({1'b0, rd});

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr;
        cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
        rsp_ready = (rsp_w == 0);
        @(posedge clk);
        acc_t = $time;
        if (b2b) check("c2c_cycles", (acc_t - prev_acc_t) / 10, gap_exp);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom();
        cmd_addr  = $urandom();

        k = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            if (k < lim) begin
                check("cmd_ready_busy", cmd_ready, 0);
                check("rsp_valid_busy", rsp_valid, 0);
                if (c.write) begin
                    check("awvalid", m_awvalid, k < ((aw_e < TO) ? aw_e : TO));
                    check("wvalid", m_wvalid, k < ((w_e < TO) ? w_e : TO));
                    check("bready", m_bready, k >= wr_e);
                    check("rd_chan_quiet", {m_arvalid, m_rready}, 0);
                    if (m_awvalid) check("awaddr", m_awaddr, c.addr);
                    if (m_wvalid)  check("wdata_wstrb", {m_wdata, m_wstrb}, {c.wdata, c.wstrb});
                    m_awready = (k >= aw_w);
                    m_wready  = (k >= w_w);
                    m_bvalid  = (k >= wr_e + b_w);
                end else begin
                    check("arvalid", m_arvalid, k < ((ar_e < TO) ? ar_e : TO));
                    check("rready", m_rready, k >= ar_e);
                    check("wr_chan_quiet", {m_awvalid, m_wvalid, m_bready}, 0);
                    if (m_arvalid) check("araddr", m_araddr, c.addr);
                    m_arready = (k >= ar_w);
                    m_rvalid  = (k >= ar_e + r_w);
                    m_rdata   = m_rvalid ? rd : $urandom();
                end
            end else begin
                slave_idle();
                check("rsp_valid", rsp_valid, 1);
                check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
                check("rsp_err", rsp_err, exp_q[0][32]);
                check("cmd_ready_rsp", cmd_ready, 0);
                check("bus_idle_rsp", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
                if (k >= lim + rsp_w) begin
                    rsp_ready = 1'b1;
                    got = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            @(negedge clk);
            k++;
        end
        if (!got) check("rsp_within_budget", 0, 1);
        check("rsp_valid_after", rsp_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
        rsp_ready  = 1'b0;
        slave_idle();
        prev_acc_t = acc_t;
        gap_exp    = lim + rsp_w + 2;
        b2b        = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("cmd_ready_gap", cmd_ready, 1);
            @(negedge clk);
        end
        b2b = 1'b0;
    endtask

    // Reset asserted while the write waits for B; no response may appear.
    task automatic reset_mid_write();
        check("rm_cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000_0008;
        cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'h3;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rm_bready", m_bready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_bus_cleared", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        check("rm_rsp_valid", rsp_valid, 0);
        check("rm_cmd_ready_in_reset", cmd_ready, 1);
        slave_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rm_cmd_ready_post", cmd_ready, 1);
            check("rm_rsp_valid_post", rsp_valid, 0);
        end
        b2b = 1'b0;
    endtask

    function automatic cmd_t mk_cmd(input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s);
        cmd_t c;
        c.write = w; c.addr = a; c.wdata = d; c.wstrb = s;
        return c;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        cmd_t c;
        int   aw_w, w_w, b_w, ar_w, r_w;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("reset_bus", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        check("reset_regs", {m_awaddr, m_wdata, m_wstrb}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write followed back-to-back by zero-wait read and write (4-cycle spacing).
        run_txn(mk_cmd(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF), 0, 0, 0, 0, 0, 0, 32'h0);
        run_txn(mk_cmd(1'b0, 32'h1000_0004, 32'h0, 4'h0), 0, 0, 0, 0, 0, 0, 32'hA5A5_0001);
        check("c2c_zero_wait_is_4", gap_exp, 4);
        run_txn(mk_cmd(1'b1, 32'h1000_0008, 32'h0102_0304, 4'h5), 0, 0, 0, 0, 0, 0, 32'h0);
        // Read with three R wait cycles.
        run_txn(mk_cmd(1'b0, 32'h2000_0010, 32'h0, 4'h0), 0, 0, 0, 0, 3, 1, 32'h1234_5678);
        // W five cycles after AW, then the reverse.
        run_txn(mk_cmd(1'b1, 32'h2000_0020, 32'h1111_2222, 4'hC), 0, 5, 1, 0, 0, 0, 32'h0);
        run_txn(mk_cmd(1'b1, 32'h2000_0024, 32'h3333_4444, 4'h3), 5, 0, 0, 0, 0, 2, 32'h0);
        // AR never accepted: timeout, then a normal command.
        run_txn(mk_cmd(1'b0, 32'h4000_0000, 32'h0, 4'h0), 0, 0, 0, 60, 0, 0, 32'h0);
        run_txn(mk_cmd(1'b0, 32'h4000_0004, 32'h0, 4'h0), 0, 0, 0, 1, 1, 0, 32'h0BAD_CAFE);
        // R handshake exactly at expiry completes; one cycle later is a timeout.
        run_txn(mk_cmd(1'b0, 32'h4000_0008, 32'h0, 4'h0), 0, 0, 0, 14, 0, 0, 32'h7777_8888);
        run_txn(mk_cmd(1'b0, 32'h4000_000C, 32'h0, 4'h0), 0, 0, 0, 15, 0, 0, 32'h9999_AAAA);
        // Same boundary on the B channel, and W never accepted.
        run_txn(mk_cmd(1'b1, 32'h4000_0010, 32'h5555_6666, 4'hF), 0, 0, 14, 0, 0, 0, 32'h0);
        run_txn(mk_cmd(1'b1, 32'h4000_0014, 32'h5555_7777, 4'hF), 0, 0, 15, 0, 0, 0, 32'h0);
        run_txn(mk_cmd(1'b1, 32'h4000_0018, 32'h5555_8888, 4'h1), 0, 40, 0, 0, 0, 1, 32'h0);
        // Response held off for ten cycles.
        run_txn(mk_cmd(1'b0, 32'h5000_0000, 32'h0, 4'h0), 0, 0, 0, 2, 2, 10, 32'hFEED_0010);

        for (int n = 0; n < 40; n++) begin
            c = mk_cmd(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
                       4'($urandom_range(0, 15)));
            aw_w = $urandom_range(0, 4);
            w_w  = $urandom_range(0, 4);
            b_w  = $urandom_range(0, 3);
            ar_w = $urandom_range(0, 4);
            r_w  = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) begin
                b_w = $urandom_range(8, 18);
                r_w = $urandom_range(8, 18);
            end
            run_txn(c, aw_w, w_w, b_w, ar_w, r_w, $urandom_range(0, 3), $urandom());
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        reset_mid_write();
        run_txn(mk_cmd(1'b0, 32'h6000_0000, 32'h0, 4'h0), 0, 0, 0, 0, 0, 0, 32'h600D_D00D);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
